// File: rtl/led_bank_arbiter_pkg.sv
// Shared definitions for the LED bank arbiter: FSM state type, default
// data width, requester-count limits and their elaboration-time check.
package led_arb_pkg;

    // Owner FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Default LED/data width
    localparam int LED_WIDTH_DEFAULT = 8;

    // Supported requester count range; the owner index port is 2 bits wide
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 4;
    localparam int ID_W        = 2;

    // True when a requester count fits the 2-bit owner index
    function automatic bit num_req_ok(input int n);
        return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
    endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found scanning upward from rr_ptr+1, wrapping modulo NUM_REQ. The
// requester at rr_ptr itself is considered last.
module rr_pick
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [NUM_REQ_MAX-1:0] req_pad;

    assign req_pad = NUM_REQ_MAX'(req);

    // Scan requesters starting after the last owner; first hit wins
    always_comb begin
        int unsigned idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!any && req_pad[idx[ID_W-1:0]]) begin
                any    = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// LED bank arbiter: shares the LED bank between NUM_REQ requesters with
// round-robin arbitration and a minimum hold time per owner. The owner's
// data is registered onto led one cycle after it is presented.
// Optional build macro LED_IDLE_BLANK_EN: when defined, led is forced to
// zero whenever the bank goes idle; otherwise it keeps the last owner's value.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int WIDTH       = LED_WIDTH_DEFAULT,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         led,
    output logic [ID_W-1:0]          active_id,
    output logic                     busy
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
        $error("led_bank_arbiter: NUM_REQ must be 2..4");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("led_bank_arbiter: HOLD_CYCLES must be >= 1");
    end

    arb_state_t             state;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       hold_cnt;

    logic                   pick_any;
    logic [ID_W-1:0]        pick_w;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [NUM_REQ_MAX-1:0] req_pad;
    logic [WIDTH-1:0]       data_arr [NUM_REQ_MAX];
    logic                   owner_req;
    logic [WIDTH-1:0]       owner_data;
    logic                   other_pending;

    // Unpack requester data into a fixed-depth array indexed by owner id
    for (genvar g = 0; g < NUM_REQ_MAX; g++) begin : g_data
        if (g < NUM_REQ) begin : g_used
            assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
        end else begin : g_unused
            assign data_arr[g] = '0;
        end
    end

    assign req_pad       = NUM_REQ_MAX'(req);
    assign owner_req     = req_pad[active_id];
    assign owner_data    = data_arr[active_id];
    assign other_pending = |(req & ~gnt);
    assign pick_onehot   = NUM_REQ'(1) << pick_w;

    // The owner sits at rr_ptr and is scanned last, so the same picker
    // serves both IDLE arbitration and preemption.
    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .winner (pick_w)
    );

    // Ownership FSM with registered grant, owner id, busy and LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            led       <= '0;
            busy      <= 1'b0;
            active_id <= '0;
            hold_cnt  <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick_onehot;
                        active_id <= pick_w;
                        busy      <= 1'b1;
                        rr_ptr    <= pick_w;
                        hold_cnt  <= '0;
                        state     <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!owner_req) begin
                        // Release beats preemption; new requests wait for IDLE
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
`ifdef LED_IDLE_BLANK_EN
                        led   <= '0;
`else
                        led   <= owner_data;
`endif
                    end else begin
                        led <= owner_data;
                        if ((hold_cnt == HOLD_MAX) && other_pending) begin
                            gnt       <= pick_onehot;
                            active_id <= pick_w;
                            rr_ptr    <= pick_w;
                            hold_cnt  <= '0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter (NUM_REQ=3, WIDTH=8, HOLD_CYCLES=4).
// Each stimulus step drives inputs on the falling edge and queues the
// outputs expected after the next rising edge; a monitor pops and compares.
module tb_led_bank_arbiter;

    typedef struct {
        logic [2:0] gnt;
        logic [7:0] led;
        logic       busy;
        logic [1:0] id;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  gnt;
    logic [7:0]  led;
    logic [1:0]  active_id;
    logic        busy;

    logic [7:0]  d0 = 8'hA5;
    logic [7:0]  d1 = 8'h5A;
    logic [7:0]  d2 = 8'h3C;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .NUM_REQ     (3),
        .WIDTH       (8),
        .HOLD_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .led       (led),
        .active_id (active_id),
        .busy      (busy)
    );

    // LED value expected while idle, given the last owner's sampled data
    function automatic logic [7:0] idle_led(input logic [7:0] held);
`ifdef LED_IDLE_BLANK_EN
        return 8'h00;
`else
        return held;
`endif
    endfunction

    task automatic step(input logic r, input logic [2:0] q, input logic [2:0] eg,
                        input logic [7:0] el, input logic eb, input logic [1:0] ei,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        req      = q;
        req_data = {d2, d1, d0};
        e.gnt = eg; e.led = el; e.busy = eb; e.id = ei; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare DUT outputs just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (gnt !== e.gnt || led !== e.led || busy !== e.busy || active_id !== e.id) begin
                    bad++;
                    $display("FAIL %s: got gnt=%b led=%h busy=%b id=%0d, want gnt=%b led=%h busy=%b id=%0d",
                             e.name, gnt, led, busy, active_id, e.gnt, e.led, e.busy, e.id);
                end
            end
        end
    end

    initial begin
        // Reset, first grant, led lag, release
        step(1, 3'b000, 3'b000, 8'h00, 0, 0, "reset");
        step(0, 3'b001, 3'b001, 8'h00, 1, 0, "grant0_latency");
        step(0, 3'b001, 3'b001, 8'hA5, 1, 0, "led_a5");
        step(0, 3'b000, 3'b000, idle_led(8'hA5), 0, 0, "release0");

        // Continuous 011: hold then preempt without a gap, and back
        step(1, 3'b011, 3'b000, 8'h00, 0, 0, "reset2");
        step(0, 3'b011, 3'b001, 8'h00, 1, 0, "rr_grant0");
        for (int i = 0; i < 4; i++)
            step(0, 3'b011, 3'b001, 8'hA5, 1, 0, "hold0");
        step(0, 3'b011, 3'b010, 8'hA5, 1, 1, "preempt_to1");
        for (int i = 0; i < 4; i++)
            step(0, 3'b011, 3'b010, 8'h5A, 1, 1, "hold1");
        step(0, 3'b011, 3'b001, 8'h5A, 1, 0, "preempt_to0");

        // Owner drops req exactly when hold expires: release wins
        for (int i = 0; i < 4; i++)
            step(0, 3'b011, 3'b001, 8'hA5, 1, 0, "hold0_again");
        step(0, 3'b010, 3'b000, idle_led(8'hA5), 0, 0, "release_wins");
        step(0, 3'b010, 3'b010, idle_led(8'hA5), 1, 1, "grant1_after_gap");
        step(0, 3'b010, 3'b010, 8'h5A, 1, 1, "led_5a");

        // Lone owner holds indefinitely past saturation
        step(0, 3'b100, 3'b000, idle_led(8'h5A), 0, 1, "release1");
        step(0, 3'b100, 3'b100, idle_led(8'h5A), 1, 2, "grant2");
        for (int i = 0; i < 20; i++)
            step(0, 3'b100, 3'b100, 8'h3C, 1, 2, "saturated_hold2");

        // Reset mid-ownership, then req=111 grants 0 first
        step(1, 3'b100, 3'b000, 8'h00, 0, 0, "reset_owned");
        step(0, 3'b111, 3'b001, 8'h00, 1, 0, "post_reset_grant0");
        step(0, 3'b111, 3'b001, 8'hA5, 1, 0, "post_reset_led");
        d0 = 8'hF0;
        step(0, 3'b111, 3'b001, 8'hF0, 1, 0, "led_f0");
        step(0, 3'b000, 3'b000, idle_led(8'hF0), 0, 0, "release_f0");
        step(0, 3'b000, 3'b000, idle_led(8'hF0), 0, 0, "idle_led_f0");

        // Single-cycle request still wins one cycle of ownership
        step(0, 3'b010, 3'b010, idle_led(8'hF0), 1, 1, "pulse_grant1");
        step(0, 3'b000, 3'b000, idle_led(8'h5A), 0, 1, "pulse_release");
        step(0, 3'b000, 3'b000, idle_led(8'h5A), 0, 1, "pulse_idle");

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
